// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: RAM word, RAM handshake status and the
// bus arbiter FSM state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arb_state_t;

   // Width of the arbiter watchdog counter.
   localparam int WDOG_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Round-robin find-first: returns the first asserted request at or after
// ptr, wrapping modulo N. Purely combinational.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Scan offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPUS cores, each with an
// instruction and a data source (source 2c = core c data, 2c+1 = core c
// instruction). One grant at a time, one IDLE bubble after each completion.
// Optional feature: define ARB_WATCHDOG_EN to build the SERVE-state watchdog
// that raises the sticky arb_timeout flag; otherwise arb_timeout is tied 0.
module bus_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS       = 2,
   parameter int WDOG_LIMIT = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [CPUS-1:0]       iREN,
   input  word_t [CPUS-1:0]      iaddr,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  word_t [CPUS-1:0]      daddr,
   input  word_t [CPUS-1:0]      dstore,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0]       dwait,
   output word_t [CPUS-1:0]      iload,
   output word_t [CPUS-1:0]      dload,
   input  ramstate_t             ramstate,
   input  word_t                 ramload,
   output word_t                 ramaddr,
   output word_t                 ramstore,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic                  arb_timeout
);

   localparam int NS = 2 * CPUS;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   arb_state_t    state, state_n;
   logic [IW-1:0] owner, owner_n;
   logic [IW-1:0] rr_ptr, rr_ptr_n;
   logic [NS-1:0] req;
   logic          pick_vld;
   logic [IW-1:0] pick_idx;
   logic          own_live;

   function automatic logic [IW-1:0] next_src(input logic [IW-1:0] s);
      return (s == IW'(NS - 1)) ? '0 : s + IW'(1);
   endfunction

   // Flatten core requests into the source vector; read wins over write.
   always_comb begin
      req = '0;
      for (int c = 0; c < CPUS; c++) begin
         req[2*c]   = dREN[c] | dWEN[c];
         req[2*c+1] = iREN[c];
      end
   end

   rr_picker #(
      .N  (NS),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Route the owner's live request to the RAM and hand back wait/load.
   always_comb begin
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      iwait    = '1;
      dwait    = '1;
      iload    = '0;
      dload    = '0;
      own_live = 1'b0;
      if (state == SERVE) begin
         for (int c = 0; c < CPUS; c++) begin
            if (owner == IW'(2*c)) begin
               own_live = dREN[c] | dWEN[c];
               ramaddr  = daddr[c];
               ramstore = dstore[c];
               ramREN   = dREN[c];
               ramWEN   = dWEN[c] & ~dREN[c];
               if (own_live && ramstate == ACCESS) begin
                  dwait[c] = 1'b0;
                  if (dREN[c]) dload[c] = ramload;
               end
            end
            if (owner == IW'(2*c+1)) begin
               own_live = iREN[c];
               ramaddr  = iaddr[c];
               ramREN   = iREN[c];
               if (own_live && ramstate == ACCESS) begin
                  iwait[c] = 1'b0;
                  iload[c] = ramload;
               end
            end
         end
      end
   end

   // Grant on any request from IDLE; leave SERVE on completion or abort.
   always_comb begin
      state_n  = state;
      owner_n  = owner;
      rr_ptr_n = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               owner_n = pick_idx;
               state_n = SERVE;
            end
         end
         SERVE: begin
            if (!own_live) begin
               // Abandoned request: no completion, so fairness pointer stays.
               state_n = IDLE;
            end else if (ramstate == ACCESS) begin
               state_n  = IDLE;
               rr_ptr_n = next_src(owner);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM, owner and round-robin pointer registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         owner  <= owner_n;
         rr_ptr <= rr_ptr_n;
      end
   end

`ifdef ARB_WATCHDOG_EN
   logic [WDOG_W-1:0] wd_cnt;
   logic              to_q;
   logic              wd_hit;

   // wd_cnt holds completed SERVE cycles; +1 counts the current one.
   assign wd_hit      = (state == SERVE) && ((int'(wd_cnt) + 1) >= WDOG_LIMIT);
   assign arb_timeout = to_q | wd_hit;

   // Watchdog counter restarts per grant; timeout flag is sticky until reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wd_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         if (state == IDLE && pick_vld)
            wd_cnt <= '0;
         else if (state == SERVE && wd_cnt != '1)
            wd_cnt <= wd_cnt + WDOG_W'(1);
         if (wd_hit)
            to_q <= 1'b1;
      end
   end
`else
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (CPUS=2, WDOG_LIMIT=4): expected grants
// are queued when requests are driven and popped when a wait goes low.
module tb_bus_arbiter;
   import cpu_types_pkg::*;

   localparam int CPUS = 2;
`ifdef ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   typedef struct {
      int    src;
      word_t addr;
   } exp_t;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic [CPUS-1:0]    iREN = '0;
   word_t [CPUS-1:0]   iaddr = '0;
   logic [CPUS-1:0]    dREN = '0;
   logic [CPUS-1:0]    dWEN = '0;
   word_t [CPUS-1:0]   daddr = '0;
   word_t [CPUS-1:0]   dstore = '0;
   logic [CPUS-1:0]    iwait;
   logic [CPUS-1:0]    dwait;
   word_t [CPUS-1:0]   iload;
   word_t [CPUS-1:0]   dload;
   ramstate_t          ramstate = FREE;
   word_t              ramload = '0;
   word_t              ramaddr;
   word_t              ramstore;
   logic               ramREN;
   logic               ramWEN;
   logic               arb_timeout;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   bus_arbiter #(.CPUS(CPUS), .WDOG_LIMIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramstate(ramstate), .ramload(ramload),
      .ramaddr(ramaddr), .ramstore(ramstore),
      .ramREN(ramREN), .ramWEN(ramWEN), .arb_timeout(arb_timeout)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      next_cycle();
      RST = 1'b1;
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramstate = FREE; ramload = '0;
      next_cycle();
      RST = 1'b0;
   endtask

   // Source whose wait is low: -1 none, -2 more than one.
   function automatic int src_of();
      int s = -1;
      int n = 0;
      for (int c = 0; c < CPUS; c++) begin
         if (dwait[c] === 1'b0) begin s = 2*c;   n++; end
         if (iwait[c] === 1'b0) begin s = 2*c+1; n++; end
      end
      if (n > 1) s = -2;
      return s;
   endfunction

   function automatic word_t load_of(input int s);
      return (s % 2 == 1) ? iload[s/2] : dload[s/2];
   endfunction

   task automatic test_reset();
      do_reset();
      settle();
      checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++;
         $display("FAIL reset_en: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
      checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++;
         $display("FAIL reset_wait: got iwait=%b dwait=%b want 11 11", iwait, dwait); end
      checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++;
         $display("FAIL reset_addr: got addr=%h store=%h want 0 0", ramaddr, ramstore); end
      checks++; if (arb_timeout !== 1'b0) begin errors++;
         $display("FAIL reset_timeout: got %b want 0", arb_timeout); end
   endtask

   task automatic test_single_read();
      exp_t e;
      int   s;
      do_reset();
      dREN[0] = 1'b1; daddr[0] = 32'h100;
      sb.push_back('{0, 32'h100});
      settle();
      checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++;
         $display("FAIL single_idle: got ren=%b dwait=%b want 0 11", ramREN, dwait); end
      next_cycle(); ramstate = BUSY; settle();
      checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin errors++;
         $display("FAIL single_serve: got ren=%b wen=%b addr=%h want 1 0 100", ramREN, ramWEN, ramaddr); end
      checks++; if (dwait[0] !== 1'b1) begin errors++;
         $display("FAIL single_busy_wait: got %b want 1", dwait[0]); end
      next_cycle(); ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
      s = src_of();
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL single_sb: got empty queue want entry"); end
      else begin
         e = sb.pop_front();
         if (s !== e.src || dload[0] !== 32'hDEADBEEF || ramaddr !== e.addr) begin errors++;
            $display("FAIL single_grant: got src=%0d dload=%h addr=%h want %0d deadbeef %h",
                     s, dload[0], ramaddr, e.src, e.addr); end
      end
      next_cycle(); ramstate = FREE; settle();
      checks++; if (dwait[0] !== 1'b1 || ramREN !== 1'b0) begin errors++;
         $display("FAIL single_bubble: got dwait0=%b ren=%b want 1 0", dwait[0], ramREN); end
      next_cycle(); dREN[0] = 1'b0; settle();
   endtask

   task automatic test_round_robin();
      exp_t  e;
      int    s, grants, last, nz;
      word_t a;
      do_reset();
      for (int c = 0; c < CPUS; c++) begin
         dREN[c] = 1'b1; iREN[c] = 1'b1;
         daddr[c] = 32'h1000 + 32'(16*c);
         iaddr[c] = 32'h2000 + 32'(16*c);
      end
      ramstate = ACCESS;
      for (int g = 0; g < 5; g++) begin
         s = g % 4;
         a = (s % 2 == 1) ? 32'h2000 + 32'(16*(s/2)) : 32'h1000 + 32'(16*(s/2));
         sb.push_back('{s, a});
      end
      grants = 0; last = -1;
      for (int cyc = 0; cyc < 30 && grants < 5; cyc++) begin
         if (cyc > 0) next_cycle();
         ramload = 32'hC0DE0000 + 32'(cyc);
         settle();
         s = src_of();
         if (s != -1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rr_sb: got empty queue want entry"); end
            else begin
               e = sb.pop_front();
               if (s !== e.src || ramaddr !== e.addr || s < 0 || load_of(s) !== ramload) begin errors++;
                  $display("FAIL rr_grant%0d: got src=%0d addr=%h want %0d %h", grants, s, ramaddr, e.src, e.addr); end
            end
            nz = 0;
            for (int c = 0; c < CPUS; c++) begin
               if (2*c != s && dload[c] !== 32'h0) nz = 1;
               if (2*c+1 != s && iload[c] !== 32'h0) nz = 1;
            end
            checks++; if (nz != 0) begin errors++;
               $display("FAIL rr_nonowner_load%0d: got nonzero want 0", grants); end
            checks++;
            if (grants == 0 && cyc != 1) begin errors++;
               $display("FAIL rr_latency: got grant cycle %0d want 1", cyc); end
            else if (grants > 0 && cyc - last != 2) begin errors++;
               $display("FAIL rr_gap%0d: got %0d cycles want 2", grants, cyc - last); end
            last = cyc;
            grants++;
         end
      end
      checks++; if (grants != 5) begin errors++;
         $display("FAIL rr_count: got %0d grants want 5", grants); end
      sb.delete();
      next_cycle(); iREN = '0; dREN = '0; ramstate = FREE; settle();
   endtask

   task automatic test_write();
      exp_t e;
      int   s;
      do_reset();
      dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h12345678;
      sb.push_back('{2, 32'h40});
      settle();
      next_cycle(); ramstate = BUSY; settle();
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h12345678 || ramaddr !== 32'h40) begin errors++;
         $display("FAIL write_serve: got wen=%b ren=%b store=%h addr=%h want 1 0 12345678 40",
                  ramWEN, ramREN, ramstore, ramaddr); end
      checks++; if (dwait[1] !== 1'b1) begin errors++;
         $display("FAIL write_busy_wait: got %b want 1", dwait[1]); end
      next_cycle(); ramstate = ACCESS; ramload = 32'h55AA55AA; settle();
      s = src_of();
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL write_sb: got empty queue want entry"); end
      else begin
         e = sb.pop_front();
         if (s !== e.src || dwait[1] !== 1'b0 || ramWEN !== 1'b1) begin errors++;
            $display("FAIL write_grant: got src=%0d dwait1=%b wen=%b want %0d 0 1", s, dwait[1], ramWEN, e.src); end
      end
      next_cycle(); dWEN = '0; ramstate = FREE; settle();
   endtask

   task automatic test_abort();
      exp_t e;
      int   s;
      bit   got;
      do_reset();
      iREN[0] = 1'b1; iaddr[0] = 32'h300; ramstate = BUSY;
      settle();
      next_cycle(); settle();
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++;
         $display("FAIL abort_serve: got ren=%b addr=%h want 1 300", ramREN, ramaddr); end
      next_cycle();
      iREN[0] = 1'b0;
      dREN[0] = 1'b1; daddr[0] = 32'h500;
      dREN[1] = 1'b1; daddr[1] = 32'h600;
      sb.push_back('{0, 32'h500});
      settle();
      checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++;
         $display("FAIL abort_drop: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
      got = 1'b0;
      for (int cyc = 0; cyc < 6 && !got; cyc++) begin
         next_cycle(); ramstate = ACCESS; ramload = 32'hABCD0001; settle();
         s = src_of();
         if (s != -1) begin
            got = 1'b1;
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL abort_sb: got empty queue want entry"); end
            else begin
               e = sb.pop_front();
               if (s !== e.src || ramaddr !== e.addr) begin errors++;
                  $display("FAIL abort_next_grant: got src=%0d addr=%h want %0d %h", s, ramaddr, e.src, e.addr); end
            end
         end
      end
      checks++; if (!got) begin errors++;
         $display("FAIL abort_wait: got no grant within 6 cycles want grant"); end
      sb.delete();
      next_cycle(); dREN = '0; ramstate = FREE; settle();
   endtask

   task automatic test_reset_mid_serve();
      exp_t e;
      int   s;
      do_reset();
      dREN[0] = 1'b1; daddr[0] = 32'h700; ramstate = ACCESS;
      settle();
      next_cycle(); settle();
      checks++; if (src_of() !== 0) begin errors++;
         $display("FAIL rst_mid_first: got src=%0d want 0", src_of()); end
      next_cycle(); dREN[0] = 1'b0; dREN[1] = 1'b1; daddr[1] = 32'h800; ramstate = BUSY; settle();
      next_cycle(); settle();
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin errors++;
         $display("FAIL rst_mid_serve: got ren=%b addr=%h want 1 800", ramREN, ramaddr); end
      next_cycle(); RST = 1'b1; settle();
      next_cycle(); RST = 1'b0; dREN[0] = 1'b1; daddr[0] = 32'h900; settle();
      checks++; if (ramREN !== 1'b0 || iwait !== 2'b11 || dwait !== 2'b11 || ramaddr !== 32'h0) begin errors++;
         $display("FAIL rst_mid_idle: got ren=%b iwait=%b dwait=%b addr=%h want 0 11 11 0",
                  ramREN, iwait, dwait, ramaddr); end
      sb.push_back('{0, 32'h900});
      next_cycle(); ramstate = ACCESS; ramload = 32'h0BADF00D; settle();
      s = src_of();
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL rst_mid_sb: got empty queue want entry"); end
      else begin
         e = sb.pop_front();
         if (s !== e.src || ramaddr !== e.addr || dload[0] !== 32'h0BADF00D) begin errors++;
            $display("FAIL rst_mid_ptr: got src=%0d addr=%h want %0d %h", s, ramaddr, e.src, e.addr); end
      end
      next_cycle(); dREN = '0; ramstate = FREE; settle();
   endtask

   task automatic test_watchdog();
      bit exp_to;
      do_reset();
      dREN[0] = 1'b1; daddr[0] = 32'hA00; ramstate = BUSY;
      settle();
      checks++; if (arb_timeout !== 1'b0) begin errors++;
         $display("FAIL wdog_idle: got %b want 0", arb_timeout); end
      for (int k = 1; k <= 6; k++) begin
         next_cycle(); settle();
         exp_to = WD_ON && (k >= 4);
         checks++; if (arb_timeout !== exp_to || ramREN !== 1'b1) begin errors++;
            $display("FAIL wdog_serve%0d: got to=%b ren=%b want %b 1", k, arb_timeout, ramREN, exp_to); end
      end
      next_cycle(); ramstate = ACCESS; ramload = 32'h600D600D; settle();
      checks++; if (dwait[0] !== 1'b0 || arb_timeout !== WD_ON) begin errors++;
         $display("FAIL wdog_access: got dwait0=%b to=%b want 0 %b", dwait[0], arb_timeout, WD_ON); end
      next_cycle(); dREN = '0; ramstate = FREE; settle();
      checks++; if (arb_timeout !== WD_ON) begin errors++;
         $display("FAIL wdog_sticky: got %b want %b", arb_timeout, WD_ON); end
      do_reset();
      settle();
      checks++; if (arb_timeout !== 1'b0) begin errors++;
         $display("FAIL wdog_clear: got %b want 0", arb_timeout); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_abort();
      test_reset_mid_serve();
      test_watchdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
